reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 27 ++
 rtl/reg_write_arbiter.sv | 91 +++++++++
 tb/tb_reg_write_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared sizes, FSM state encoding and a one-hot helper for the register write arbiter.
package reg_arb_pkg;
  localparam int N_REQ = 4;
  localparam int W     = 4;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    to_onehot      = '0;
    to_onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr, wrapping N_REQ-1 -> 0.
module rr_pick
  import reg_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Scanning from the farthest offset down leaves the nearest set request as the winner.
  always_comb begin
    valid  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates N_REQ requesters for writes into one shared W-bit register, one write per 4 cycles.
//   state | meaning
//   IDLE  | waiting; samples req and latches the round-robin winner
//   GRANT | gnt[winner] high; captures wdata if the winner still requests, else aborts
//   WRITE | wr_strobe high; shared register loads at the closing edge
//   ACK   | ack[winner] pulses; always returns to IDLE
module reg_write_arbiter
  import reg_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic               wr_strobe,
  output logic [W-1:0]       q,
  output logic               busy
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [W-1:0]     data_q;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  rr_pick u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Outputs are registered alongside the next state so each one is a clean decode of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      data_q    <= '0;
      q         <= '0;
      gnt       <= '0;
      ack       <= '0;
      wr_strobe <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt       <= '0;
      ack       <= '0;
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner <= pick_idx;
            gnt    <= to_onehot(pick_idx);
            busy   <= 1'b1;
            state  <= GRANT;
          end else begin
            busy <= 1'b0;
          end
        end
        GRANT: begin
          if (req[winner]) begin
            data_q    <= wdata[int'(winner)*W +: W];
            wr_strobe <= 1'b1;
            state     <= WRITE;
          end else begin
            ptr   <= winner + IDX_W'(1);
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WRITE: begin
          q     <= data_q;
          ptr   <= winner + IDX_W'(1);
          ack   <= to_onehot(winner);
          state <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table plus hand-written abort/reset/back-to-back sequences.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  logic               clk;
  logic               reset;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] wdata;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   ack;
  logic               wr_strobe;
  logic [W-1:0]       q;
  logic               busy;

  reg_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wdata     (wdata),
    .gnt       (gnt),
    .ack       (ack),
    .wr_strobe (wr_strobe),
    .q         (q),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  q;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] q;
  } sb_t;

  int   errors = 0;
  int   checks = 0;
  sb_t  sb_q[$];
  vec_t vec[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard: every ack pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && ack != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {12'h0, ack}, 16'h0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_ack", {12'h0, ack}, {12'h0, e.ack});
        check("sb_q", {12'h0, q}, {12'h0, e.q});
      end
    end
  end

  initial begin
    logic [3:0] prev_q;
    int         n_ack;
    int         last_ack;
    int         cyc;

    reset = 1'b1;
    req   = 4'b1111;
    wdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("rst_q", {12'h0, q}, 16'h0);
    check("rst_gnt", {12'h0, gnt}, 16'h0);
    check("rst_ack", {12'h0, ack}, 16'h0);
    check("rst_wr", {15'h0, wr_strobe}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    req   = '0;
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {15'h0, busy}, 16'h0);

    // Expected winners derived by hand from the round-robin pointer history.
    vec[0] = '{req: 4'b0010, wdata: 16'h00A0, gnt: 4'b0010, q: 4'hA}; // ptr 0 -> 2
    vec[1] = '{req: 4'b0011, wdata: 16'h0057, gnt: 4'b0001, q: 4'h7}; // ptr 2 -> 1
    vec[2] = '{req: 4'b1001, wdata: 16'hE001, gnt: 4'b1000, q: 4'hE}; // ptr 1 -> 0
    vec[3] = '{req: 4'b1111, wdata: 16'h432B, gnt: 4'b0001, q: 4'hB}; // ptr 0 -> 1
    vec[4] = '{req: 4'b0100, wdata: 16'h0600, gnt: 4'b0100, q: 4'h6}; // ptr 1 -> 3
    vec[5] = '{req: 4'b1001, wdata: 16'h9005, gnt: 4'b1000, q: 4'h9}; // ptr 3 -> 0
    vec[6] = '{req: 4'b1001, wdata: 16'h9005, gnt: 4'b0001, q: 4'h5}; // ptr 0 -> 1
    vec[7] = '{req: 4'b0110, wdata: 16'h0CD0, gnt: 4'b0010, q: 4'hD}; // ptr 1 -> 2

    prev_q = 4'h0;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back('{ack: vec[i].gnt, q: vec[i].q});
      req   = vec[i].req;
      wdata = vec[i].wdata;
      @(negedge clk);
      check("vec_gnt", {12'h0, gnt}, {12'h0, vec[i].gnt});
      check("vec_busy", {15'h0, busy}, 16'h1);
      check("vec_wr_early", {15'h0, wr_strobe}, 16'h0);
      @(negedge clk);
      check("vec_wr", {15'h0, wr_strobe}, 16'h1);
      check("vec_gnt_off", {12'h0, gnt}, 16'h0);
      check("vec_q_hold", {12'h0, q}, {12'h0, prev_q});
      wdata = ~vec[i].wdata;
      @(negedge clk);
      check("vec_q", {12'h0, q}, {12'h0, vec[i].q});
      check("vec_ack", {12'h0, ack}, {12'h0, vec[i].gnt});
      req = '0;
      @(negedge clk);
      check("vec_busy_end", {15'h0, busy}, 16'h0);
      check("vec_ack_end", {12'h0, ack}, 16'h0);
      prev_q = vec[i].q;
    end

    // All requesters held: strict rotation with one ack every 4 cycles.
    do_reset();
    wdata = 16'h8421;
    sb_q.push_back('{ack: 4'b0001, q: 4'h1});
    sb_q.push_back('{ack: 4'b0010, q: 4'h2});
    sb_q.push_back('{ack: 4'b0100, q: 4'h4});
    sb_q.push_back('{ack: 4'b1000, q: 4'h8});
    sb_q.push_back('{ack: 4'b0001, q: 4'h1});
    req      = 4'b1111;
    n_ack    = 0;
    last_ack = 0;
    cyc      = 0;
    while (n_ack < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        if (n_ack > 0) check("rr_ack_spacing", 16'(cyc - last_ack), 16'd4);
        last_ack = cyc;
        n_ack++;
      end
    end
    check("rr_ack_count", 16'(n_ack), 16'd5);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("rr_idle_after", {15'h0, busy}, 16'h0);

    // Request dropped during GRANT aborts without a write; pointer still advances past it.
    do_reset();
    wdata = 16'h7300;
    req   = 4'b0100;
    @(negedge clk);
    check("abort_gnt", {12'h0, gnt}, 16'h4);
    req = '0;
    @(negedge clk);
    check("abort_wr", {15'h0, wr_strobe}, 16'h0);
    check("abort_busy", {15'h0, busy}, 16'h0);
    check("abort_q", {12'h0, q}, 16'h0);
    sb_q.push_back('{ack: 4'b1000, q: 4'h7});
    req = 4'b1100;
    @(negedge clk);
    check("abort_next_gnt", {12'h0, gnt}, 16'h8);
    @(negedge clk);
    @(negedge clk);
    check("abort_next_q", {12'h0, q}, 16'h7);
    req = '0;
    @(negedge clk);

    // Reset during WRITE drops the pending load and suppresses the ack.
    do_reset();
    wdata = 16'h0060;
    req   = 4'b0010;
    @(negedge clk);
    check("wrst_gnt", {12'h0, gnt}, 16'h2);
    @(negedge clk);
    check("wrst_wr", {15'h0, wr_strobe}, 16'h1);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    check("wrst_q", {12'h0, q}, 16'h0);
    check("wrst_ack", {12'h0, ack}, 16'h0);
    check("wrst_busy", {15'h0, busy}, 16'h0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wrst_no_ack", {12'h0, ack}, 16'h0);
    end
    check("wrst_q_after", {12'h0, q}, 16'h0);

    check("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
